pc_update_unit: RTL and testbench

- Program-counter stage that sits directly downstream of the multicycle control unit.
- Consumes PCWrite, PCWriteCondbeq/bne/bge/blt and PCSource, together with the ALU flags and results, and owns the architectural PC register.
- Resolves branches and detects misaligned control-flow targets. On a misaligned target it redirects to a trap vector and holds a trap state until software acknowledges it.
- Maintains retired-instruction and taken-branch counters for debug.

---
 rtl/pc_update_unit.sv | 138 +++++++++++++
 tb/tb_pc_update_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pc_update_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_update_unit
// Description : Program-counter stage downstream of the multicycle control
//               unit. Owns the architectural PC, resolves conditional
//               branches from the current ALU flags, and traps misaligned
//               control-flow targets to TRAP_VECTOR. The trap is held until
//               trap_ack. Also keeps debug counters for retired fetches and
//               taken branches.
//
// Ports       : clk, reset          - clock, synchronous active-high reset
//               PCWrite             - unconditional PC write (fetch)
//               PCWriteCond{beq,bne,bge,blt} - conditional write strobes
//               PCSource            - 0: alu_result, 1: alu_out
//               alu_result, alu_out - candidate next-PC values
//               zero, lt            - ALU flags of the current cycle
//               trap_ack            - leaves the trap state
//               pc                  - architectural PC
//               pc_loaded           - PC changed on the previous edge
//               branch_taken        - conditional write taken this cycle
//               trap_pending        - trap state active
//               epc, bad_target     - PC and target captured at trap entry
//               instret_cnt         - accepted sequential fetch writes
//               br_taken_cnt        - accepted taken branches
//
// Revision    : 1.0 - initial release
// ============================================================================
module pc_update_unit #(
    parameter int              XLEN        = 64,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR = 64'h100,
    parameter int              CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             PCWrite,
    input  logic             PCWriteCondbeq,
    input  logic             PCWriteCondbne,
    input  logic             PCWriteCondbge,
    input  logic             PCWriteCondblt,
    input  logic             PCSource,
    input  logic [XLEN-1:0]  alu_result,
    input  logic [XLEN-1:0]  alu_out,
    input  logic             zero,
    input  logic             lt,
    input  logic             trap_ack,
    output logic [XLEN-1:0]  pc,
    output logic             pc_loaded,
    output logic             branch_taken,
    output logic             trap_pending,
    output logic [XLEN-1:0]  epc,
    output logic [XLEN-1:0]  bad_target,
    output logic [CNT_W-1:0] instret_cnt,
    output logic [CNT_W-1:0] br_taken_cnt
);

    localparam logic [0:0]       c_ST_RUN  = 1'b0;
    localparam logic [0:0]       c_ST_TRAP = 1'b1;
    localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_epc;
    logic [XLEN-1:0]  r_bad_target;
    logic             r_pc_loaded;
    logic [CNT_W-1:0] r_instret_cnt;
    logic [CNT_W-1:0] r_br_taken_cnt;

    logic             w_in_run;
    logic             w_taken;
    logic             w_we;
    logic [XLEN-1:0]  w_target;
    logic             w_mis;
    logic             w_accept;

    assign w_in_run = (r_state == c_ST_RUN);

    // Several strobes in one cycle simply OR together.
    assign w_taken  = (PCWriteCondbeq &  zero) | (PCWriteCondbne & ~zero) |
                      (PCWriteCondbge & ~lt)   | (PCWriteCondblt &  lt);
    assign w_we     = PCWrite | w_taken;
    assign w_target = PCSource ? alu_out : alu_result;
    // Only 4-byte aligned targets are legal (no compressed instructions).
    assign w_mis    = w_we & (w_target[1:0] != 2'b00);
    // Write inputs are only honoured in RUN; TRAP ignores them entirely.
    assign w_accept = w_in_run & w_we;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_RUN:  if (w_we && w_mis) w_state_next = c_ST_TRAP;
            c_ST_TRAP: if (trap_ack)      w_state_next = c_ST_RUN;
            default:                      w_state_next = c_ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_ST_RUN;
            r_pc           <= RESET_PC;
            r_epc          <= '0;
            r_bad_target   <= '0;
            r_pc_loaded    <= 1'b0;
            r_instret_cnt  <= '0;
            r_br_taken_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pc_loaded <= 1'b0;
            if (w_accept) begin
                r_pc_loaded <= 1'b1;
                if (w_mis) begin
                    r_pc         <= TRAP_VECTOR;
                    r_epc        <= r_pc;
                    r_bad_target <= w_target;
                end else begin
                    r_pc <= w_target;
                    // Only PC+4 fetch writes count as retired instructions.
                    if (PCWrite && !PCSource)
                        r_instret_cnt <= r_instret_cnt + c_CNT_ONE;
                    if (w_taken)
                        r_br_taken_cnt <= r_br_taken_cnt + c_CNT_ONE;
                end
            end
        end
    end

    assign pc           = r_pc;
    assign pc_loaded    = r_pc_loaded;
    assign branch_taken = w_taken & w_in_run;
    assign trap_pending = (r_state == c_ST_TRAP);
    assign epc          = r_epc;
    assign bad_target   = r_bad_target;
    assign instret_cnt  = r_instret_cnt;
    assign br_taken_cnt = r_br_taken_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pc_update_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_update_unit
// Description : Self-checking bench for pc_update_unit (CNT_W = 4 so that
//               counter wrap is reachable). Directed table of vectors with
//               explicit expectations, hand sequences for wrap and
//               reset-in-trap, then random stimulus against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_update_unit;

    localparam int XLEN  = 64;
    localparam int CNT_W = 4;
    localparam logic [XLEN-1:0] c_TRAP_VEC = 64'h100;

    logic             clk = 1'b0;
    logic             reset;
    logic             PCWrite, PCWriteCondbeq, PCWriteCondbne;
    logic             PCWriteCondbge, PCWriteCondblt, PCSource;
    logic [XLEN-1:0]  alu_result, alu_out;
    logic             zero, lt, trap_ack;
    logic [XLEN-1:0]  pc, epc, bad_target;
    logic             pc_loaded, branch_taken, trap_pending;
    logic [CNT_W-1:0] instret_cnt, br_taken_cnt;

    always #5 clk = ~clk;

    pc_update_unit #(
        .XLEN       (XLEN),
        .RESET_PC   (64'h0),
        .TRAP_VECTOR(c_TRAP_VEC),
        .CNT_W      (CNT_W)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .PCWrite       (PCWrite),
        .PCWriteCondbeq(PCWriteCondbeq),
        .PCWriteCondbne(PCWriteCondbne),
        .PCWriteCondbge(PCWriteCondbge),
        .PCWriteCondblt(PCWriteCondblt),
        .PCSource      (PCSource),
        .alu_result    (alu_result),
        .alu_out       (alu_out),
        .zero          (zero),
        .lt            (lt),
        .trap_ack      (trap_ack),
        .pc            (pc),
        .pc_loaded     (pc_loaded),
        .branch_taken  (branch_taken),
        .trap_pending  (trap_pending),
        .epc           (epc),
        .bad_target    (bad_target),
        .instret_cnt   (instret_cnt),
        .br_taken_cnt  (br_taken_cnt)
    );

    typedef struct {
        logic        rst, pw, beq, bne, bge, blt, src;
        logic [63:0] ares, aout;
        logic        z, l, ack;
        logic [63:0] e_pc;
        logic        e_ld, e_tp;
        int          e_in, e_br;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [63:0] m_pc, m_epc, m_bad;
    int          m_in, m_br;
    bit          m_ld, m_tp = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, pw, beq, bne, bge, blt, src,
                                input logic [63:0] ares, aout,
                                input logic z, l, ack,
                                input logic [63:0] e_pc, input logic e_ld, e_tp,
                                input int e_in, e_br);
        vec_t v;
        v.rst = rst; v.pw = pw; v.beq = beq; v.bne = bne; v.bge = bge; v.blt = blt;
        v.src = src; v.ares = ares; v.aout = aout; v.z = z; v.l = l; v.ack = ack;
        v.e_pc = e_pc; v.e_ld = e_ld; v.e_tp = e_tp; v.e_in = e_in; v.e_br = e_br;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        reset = v.rst; PCWrite = v.pw; PCWriteCondbeq = v.beq; PCWriteCondbne = v.bne;
        PCWriteCondbge = v.bge; PCWriteCondblt = v.blt; PCSource = v.src;
        alu_result = v.ares; alu_out = v.aout; zero = v.z; lt = v.l; trap_ack = v.ack;
    endtask

    function automatic bit m_cond();
        return (PCWriteCondbeq && zero) || (PCWriteCondbne && !zero) ||
               (PCWriteCondbge && !lt)  || (PCWriteCondblt && lt);
    endfunction

    // Architectural effect of one clock edge given the currently driven inputs.
    task automatic model_step();
        bit          tk, wr;
        logic [63:0] tgt;
        if (reset) begin
            m_pc = 0; m_epc = 0; m_bad = 0; m_in = 0; m_br = 0; m_ld = 0; m_tp = 0;
        end else if (m_tp) begin
            m_ld = 0;
            if (trap_ack) m_tp = 0;
        end else begin
            tk  = m_cond();
            wr  = PCWrite || tk;
            tgt = PCSource ? alu_out : alu_result;
            m_ld = wr;
            if (wr && (tgt % 4 != 0)) begin
                m_epc = m_pc; m_bad = tgt; m_pc = c_TRAP_VEC; m_tp = 1;
            end else if (wr) begin
                m_pc = tgt;
                if (PCWrite && !PCSource) m_in = (m_in + 1) % (1 << CNT_W);
                if (tk)                   m_br = (m_br + 1) % (1 << CNT_W);
            end
        end
    endtask

    // Inputs are already applied (1 time unit after the previous edge).
    task automatic cycle();
        #3;
        if (!reset) chk("branch_taken", 64'(branch_taken), 64'(m_cond() && !m_tp));
        model_step();
        @(posedge clk);
        #1;
        chk("pc",           pc,                  m_pc);
        chk("pc_loaded",    64'(pc_loaded),      64'(m_ld));
        chk("trap_pending", 64'(trap_pending),   64'(m_tp));
        chk("epc",          epc,                 m_epc);
        chk("bad_target",   bad_target,          m_bad);
        chk("instret_cnt",  64'(instret_cnt),    64'(m_in));
        chk("br_taken_cnt", 64'(br_taken_cnt),   64'(m_br));
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        //        rst pw beq bne bge blt src ares     aout     z  l  ack  e_pc     ld tp in br
        tbl.push_back(mk(1, 0,0,0,0,0, 0, 64'h0,   64'h0,   0, 0, 0, 64'h0,   0, 0, 0, 0));
        tbl.push_back(mk(0, 1,0,0,0,0, 0, 64'h4,   64'h0,   0, 0, 0, 64'h4,   1, 0, 1, 0));
        tbl.push_back(mk(0, 0,1,0,0,0, 1, 64'h0,   64'h40,  1, 0, 0, 64'h40,  1, 0, 1, 1));
        tbl.push_back(mk(0, 0,1,0,0,0, 1, 64'h0,   64'h80,  0, 0, 0, 64'h40,  0, 0, 1, 1));
        tbl.push_back(mk(0, 0,0,1,0,0, 1, 64'h0,   64'h80,  0, 0, 0, 64'h80,  1, 0, 1, 2));
        tbl.push_back(mk(0, 0,0,1,0,0, 1, 64'h0,   64'h80,  1, 1, 0, 64'h80,  0, 0, 1, 2));
        tbl.push_back(mk(0, 0,0,0,1,0, 1, 64'h0,   64'h80,  0, 1, 0, 64'h80,  0, 0, 1, 2));
        tbl.push_back(mk(0, 0,0,0,1,0, 1, 64'h0,   64'h80,  1, 0, 0, 64'h80,  1, 0, 1, 3));
        tbl.push_back(mk(0, 0,0,0,0,1, 1, 64'h0,   64'h80,  0, 0, 0, 64'h80,  0, 0, 1, 3));
        tbl.push_back(mk(0, 0,0,0,0,1, 1, 64'h0,   64'h80,  1, 1, 0, 64'h80,  1, 0, 1, 4));
        tbl.push_back(mk(0, 1,1,0,0,0, 1, 64'h0,   64'h10,  1, 0, 0, 64'h10,  1, 0, 1, 5));
        tbl.push_back(mk(0, 1,0,1,0,0, 0, 64'h10,  64'h0,   0, 0, 0, 64'h10,  1, 0, 2, 6));
        // misaligned branch target -> trap
        tbl.push_back(mk(0, 0,1,0,0,0, 1, 64'h0,   64'h42,  1, 0, 0, 64'h100, 1, 1, 2, 6));
        tbl.push_back(mk(0, 1,0,0,0,0, 0, 64'h200, 64'h0,   0, 0, 0, 64'h100, 0, 1, 2, 6));
        tbl.push_back(mk(0, 1,0,0,0,0, 0, 64'h200, 64'h0,   0, 0, 0, 64'h100, 0, 1, 2, 6));
        tbl.push_back(mk(0, 1,1,0,0,0, 1, 64'h200, 64'h200, 1, 0, 0, 64'h100, 0, 1, 2, 6));
        // ack with a write in the same cycle: write still ignored
        tbl.push_back(mk(0, 1,0,0,0,0, 0, 64'h200, 64'h0,   0, 0, 1, 64'h100, 0, 0, 2, 6));
        tbl.push_back(mk(0, 1,0,0,0,0, 0, 64'h104, 64'h0,   0, 0, 0, 64'h104, 1, 0, 3, 6));
        tbl.push_back(mk(0, 0,0,0,0,0, 0, 64'h0,   64'h0,   0, 0, 1, 64'h104, 0, 0, 3, 6));
        // misaligned fetch, then reset while trapped
        tbl.push_back(mk(0, 1,0,0,0,0, 0, 64'h106, 64'h0,   0, 0, 0, 64'h100, 1, 1, 3, 6));
        tbl.push_back(mk(1, 1,0,0,0,0, 0, 64'h8,   64'h0,   0, 0, 0, 64'h0,   0, 0, 0, 0));

        drive(mk(1, 0,0,0,0,0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            cycle();
            chk("tbl_pc",      pc,                tbl[i].e_pc);
            chk("tbl_loaded",  64'(pc_loaded),    64'(tbl[i].e_ld));
            chk("tbl_trap",    64'(trap_pending), 64'(tbl[i].e_tp));
            chk("tbl_instret", 64'(instret_cnt),  64'(tbl[i].e_in));
            chk("tbl_brcnt",   64'(br_taken_cnt), 64'(tbl[i].e_br));
        end
        chk("rst_trap_epc", epc, 64'h0);

        // 16 fetches wrap the 4-bit retired counter back to 0
        for (int i = 0; i < 16; i++) begin
            drive(mk(0, 1,0,0,0,0, 0, 64'(4 * (i + 1)), 0, 0, 0, 0, 0, 0, 0, 0, 0));
            cycle();
        end
        chk("instret_wrap", 64'(instret_cnt), 64'h0);
        chk("wrap_pc",      pc,               64'h40);

        // Randomized stimulus against the reference model
        for (int i = 0; i < 400; i++) begin
            v.rst  = ($urandom_range(0, 49) == 0);
            v.pw   = ($urandom_range(0, 2) == 0);
            v.beq  = ($urandom_range(0, 4) == 0);
            v.bne  = ($urandom_range(0, 4) == 0);
            v.bge  = ($urandom_range(0, 4) == 0);
            v.blt  = ($urandom_range(0, 4) == 0);
            v.src  = $urandom_range(0, 1);
            v.ares = {32'($urandom), 32'($urandom)} & ~64'h3;
            v.aout = {32'($urandom), 32'($urandom)} & ~64'h3;
            if ($urandom_range(0, 7) == 0) v.ares[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) v.aout[1:0] = 2'($urandom_range(1, 3));
            v.z    = $urandom_range(0, 1);
            v.l    = $urandom_range(0, 1);
            v.ack  = ($urandom_range(0, 3) == 0);
            drive(v);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
